framebuffer_swap: RTL and testbench

Double-buffered frame store between the ray transformation stage and the HDMI output path. Accepts one 16-bit pixel write per cycle at 320x180 resolution into the back bank while the front bank is read out, 4x nearest-neighbour upscaled, for the 1280x720 display raster. Banks swap only at a display frame boundary after the transformation stage has delivered a complete frame, so the display never shows a partially drawn frame.

---
 rtl/fb_pkg.sv | 34 +++
 rtl/framebuffer_swap_if.sv | 33 +++
 rtl/fb_bram.sv | 32 +++
 rtl/framebuffer_swap.sv | 101 ++++++++++
 tb/tb_framebuffer_swap.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared constants, write-FSM state type and read-address helper for the
// double-buffered frame store.
package fb_pkg;

  localparam int PIXEL_WIDTH        = 16;
  localparam int SCREEN_WIDTH       = 320;
  localparam int SCREEN_HEIGHT      = 180;
  localparam int FULL_SCREEN_WIDTH  = 1280;
  localparam int FULL_SCREEN_HEIGHT = 720;
  localparam int BRAM_LATENCY       = 2;
  localparam int FB_DEPTH           = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int UPSCALE_SHIFT      = 2;
  localparam int ADDR_WIDTH         = 16;
  localparam int HCOUNT_WIDTH       = 11;
  localparam int VCOUNT_WIDTH       = 10;

  typedef enum logic {
    WRITING = 1'b0,
    FULL    = 1'b1
  } t_wr_state;

  function automatic logic [ADDR_WIDTH-1:0] fb_rd_addr(
    input logic [HCOUNT_WIDTH-1:0] hcount,
    input logic [VCOUNT_WIDTH-1:0] vcount
  );
    logic [ADDR_WIDTH-1:0] src_x;
    logic [ADDR_WIDTH-1:0] src_y;
    src_x = ADDR_WIDTH'(hcount >> UPSCALE_SHIFT);
    src_y = ADDR_WIDTH'(vcount >> UPSCALE_SHIFT);
    // 320 = 256 + 64, so the row offset is two shifts and an add
    return src_x + (src_y << 8) + (src_y << 6);
  endfunction

endpackage

// File: rtl/framebuffer_swap_if.sv
// Bundles the ray write port, display raster inputs and status outputs
// of the frame store.
interface framebuffer_swap_if;
  import fb_pkg::*;

  logic                    ray_valid_in;
  logic [ADDR_WIDTH-1:0]   ray_address_in;
  logic [PIXEL_WIDTH-1:0]  ray_pixel_in;
  logic                    ray_last_pixel_in;
  logic                    write_ready_out;
  logic [HCOUNT_WIDTH-1:0] hcount_in;
  logic [VCOUNT_WIDTH-1:0] vcount_in;
  logic                    new_frame_in;
  logic [PIXEL_WIDTH-1:0]  pixel_out;
  logic                    pixel_valid_out;
  logic                    frame_swap_out;
  logic                    write_error_out;

  modport master (
    output ray_valid_in, ray_address_in, ray_pixel_in, ray_last_pixel_in,
    output hcount_in, vcount_in, new_frame_in,
    input  write_ready_out, pixel_out, pixel_valid_out, frame_swap_out,
    input  write_error_out
  );

  modport slave (
    input  ray_valid_in, ray_address_in, ray_pixel_in, ray_last_pixel_in,
    input  hcount_in, vcount_in, new_frame_in,
    output write_ready_out, pixel_out, pixel_valid_out, frame_swap_out,
    output write_error_out
  );

endinterface

// File: rtl/fb_bram.sv
// Simple dual-port RAM: one write port, one read port with a LATENCY-deep
// registered output (LATENCY must be at least 2).
module fb_bram #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 57600,
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0]                mem [DEPTH];
  logic [LATENCY-1:0][WIDTH-1:0]   pipe_q;

  // NOTE: the array and its output pipeline have no reset so they map onto
  // block RAM; a reset would force a register-based implementation.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    pipe_q <= {pipe_q[LATENCY-2:0], mem[raddr_i]};
  end

  assign rdata_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/framebuffer_swap.sv
// Double-buffered frame store: ray writes fill the back bank while the front
// bank is read 4x upscaled; banks swap only at a display frame start.
module framebuffer_swap
  import fb_pkg::*;
(
  input  logic               pixel_clk_in,
  input  logic               rst_in,
  framebuffer_swap_if.slave  fb
);

  t_wr_state               state_q, state_d;
  logic                    write_bank_q;
  logic                    frame_swap_q;
  logic                    write_error_q;
  logic                    wr_accept, wr_drop, swap;

  logic                    active_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_d, rd_addr_q;
  logic [BRAM_LATENCY:0]   active_q;
  logic [BRAM_LATENCY:0]   rd_bank_q;
  logic [PIXEL_WIDTH-1:0]  rd_data [2];

  // NOTE: every signal driven here gets a default before any branch so the
  // block stays purely combinational and never infers a latch.
  always_comb begin
    wr_accept = (state_q == WRITING) && fb.ray_valid_in &&
                (fb.ray_address_in < ADDR_WIDTH'(FB_DEPTH));
    wr_drop   = fb.ray_valid_in && !wr_accept;
    swap      = 1'b0;
    state_d   = state_q;
    case (state_q)
      WRITING: begin
        // a last pixel arriving with new_frame_in swaps at once, skipping FULL
        if (wr_accept && fb.ray_last_pixel_in) begin
          if (fb.new_frame_in) swap = 1'b1;
          else                 state_d = FULL;
        end
      end
      FULL: begin
        if (fb.new_frame_in) begin
          swap    = 1'b1;
          state_d = WRITING;
        end
      end
      default: state_d = WRITING;
    endcase
  end

  always_comb begin
    active_d  = (fb.hcount_in < HCOUNT_WIDTH'(FULL_SCREEN_WIDTH)) &&
                (fb.vcount_in < VCOUNT_WIDTH'(FULL_SCREEN_HEIGHT));
    rd_addr_d = active_d ? fb_rd_addr(fb.hcount_in, fb.vcount_in) : '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= WRITING;
      write_bank_q  <= 1'b0;
      frame_swap_q  <= 1'b0;
      write_error_q <= 1'b0;
      rd_addr_q     <= '0;
      active_q      <= '0;
      rd_bank_q     <= '0;
    end else begin
      state_q       <= state_d;
      write_bank_q  <= write_bank_q ^ swap;
      frame_swap_q  <= swap;
      write_error_q <= write_error_q | wr_drop;
      rd_addr_q     <= rd_addr_d;
      // bank select travels with its address so a swap never splits a fetch
      active_q      <= {active_q[BRAM_LATENCY-1:0], active_d};
      rd_bank_q     <= {rd_bank_q[BRAM_LATENCY-1:0], ~write_bank_q};
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fb_bram #(
      .WIDTH      (PIXEL_WIDTH),
      .DEPTH      (FB_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .LATENCY    (BRAM_LATENCY)
    ) u_bank (
      .clk     (pixel_clk_in),
      .we_i    (wr_accept && (write_bank_q == 1'(b))),
      .waddr_i (fb.ray_address_in),
      .wdata_i (fb.ray_pixel_in),
      .raddr_i (rd_addr_q),
      .rdata_o (rd_data[b])
    );
  end

  assign fb.write_ready_out = (state_q == WRITING);
  assign fb.frame_swap_out  = frame_swap_q;
  assign fb.write_error_out = write_error_q;
  assign fb.pixel_valid_out = active_q[BRAM_LATENCY];
  assign fb.pixel_out       = active_q[BRAM_LATENCY] ?
                              rd_data[rd_bank_q[BRAM_LATENCY]] : '0;

endmodule

// File: tb/tb_framebuffer_swap.sv
// Scoreboard bench for framebuffer_swap: a bank/FSM model predicts display
// pixels and write-side status, compared 3 cycles after each raster position.
module tb_framebuffer_swap;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  framebuffer_swap_if fb_if();

  framebuffer_swap dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .fb           (fb_if)
  );

  typedef struct {
    int          due;
    logic        valid;
    logic [15:0] pix;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] mem_m [2][57600];
  bit          wb_m, full_m, err_m;
  int          cyc, n_checks, n_pass;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: observed %0h, wanted %0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      check_eq("pixel_valid", fb_if.pixel_valid_out, e.valid);
      check_eq("pixel_out", fb_if.pixel_out, e.pix);
    end
  endtask

  task automatic park();
    fb_if.hcount_in = 11'd1300;
    fb_if.vcount_in = 10'd0;
  endtask

  // one display sample; its expected output is due three cycles later
  task automatic read_px(input int h, input int v);
    exp_t e;
    bit   active;
    fb_if.hcount_in = 11'(h);
    fb_if.vcount_in = 10'(v);
    active  = (h < 1280) && (v < 720);
    e.due   = cyc + 3;
    e.valid = active;
    e.pix   = active ? mem_m[!wb_m][(h / 4) + (v / 4) * 320] : 16'h0000;
    sb_q.push_back(e);
    tick();
  endtask

  task automatic drain();
    park();
    repeat (3) tick();
  endtask

  // one write-side cycle, model updated alongside, status checked after the edge
  task automatic wr(input logic valid, input logic [15:0] addr, input logic [15:0] pix,
                    input logic last, input logic nf);
    bit acc, swp;
    fb_if.ray_valid_in      = valid;
    fb_if.ray_address_in    = addr;
    fb_if.ray_pixel_in      = pix;
    fb_if.ray_last_pixel_in = last;
    fb_if.new_frame_in      = nf;
    acc = !full_m && valid && (addr < 16'd57600);
    swp = (!full_m && acc && last && nf) || (full_m && nf);
    if (acc) mem_m[wb_m][addr] = pix;
    if (valid && !acc) err_m = 1'b1;
    if (!full_m && acc && last && !nf) full_m = 1'b1;
    else if (full_m && nf) full_m = 1'b0;
    if (swp) wb_m = !wb_m;
    tick();
    fb_if.ray_valid_in      = 1'b0;
    fb_if.ray_last_pixel_in = 1'b0;
    fb_if.new_frame_in      = 1'b0;
    check_eq("write_ready", fb_if.write_ready_out, !full_m);
    check_eq("frame_swap", fb_if.frame_swap_out, swp);
    check_eq("write_error", fb_if.write_error_out, err_m);
  endtask

  task automatic idle();
    wr(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    wb_m   = 1'b0;
    full_m = 1'b0;
    err_m  = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    fb_if.ray_valid_in      = 1'b0;
    fb_if.ray_address_in    = '0;
    fb_if.ray_pixel_in      = '0;
    fb_if.ray_last_pixel_in = 1'b0;
    fb_if.new_frame_in      = 1'b0;
    park();
    repeat (3) tick();
    check_eq("rst_write_ready", fb_if.write_ready_out, 1'b1);
    check_eq("rst_write_error", fb_if.write_error_out, 1'b0);
    check_eq("rst_frame_swap", fb_if.frame_swap_out, 1'b0);
    check_eq("rst_pixel_valid", fb_if.pixel_valid_out, 1'b0);
    check_eq("rst_pixel_out", fb_if.pixel_out, 16'h0000);
    rst = 1'b0;

    // single-pixel frame, swap, then exact 3-cycle read latency
    wr(1'b1, 16'd0, 16'hF800, 1'b1, 1'b0);
    wr(1'b0, 16'd0, 16'h0000, 1'b0, 1'b1);
    idle();
    read_px(1300, 0);
    read_px(0, 0);
    read_px(1300, 0);
    drain();

    // upscale mapping and active-area edges
    wr(1'b1, 16'd321, 16'h07E0, 1'b0, 1'b0);
    wr(1'b1, 16'd322, 16'h001F, 1'b1, 1'b0);
    wr(1'b0, 16'd0, 16'h0000, 1'b0, 1'b1);
    idle();
    read_px(4, 4);
    read_px(7, 7);
    read_px(8, 4);
    read_px(1280, 0);
    read_px(0, 720);
    drain();

    // FULL back-pressure: dropped write must not overwrite stored data
    wr(1'b1, 16'd6, 16'h1111, 1'b0, 1'b0);
    wr(1'b1, 16'd5, 16'hAAAA, 1'b1, 1'b0);
    wr(1'b1, 16'd6, 16'hBBBB, 1'b0, 1'b0);
    wr(1'b0, 16'd0, 16'h0000, 1'b0, 1'b1);
    idle();
    read_px(24, 0);
    read_px(20, 0);
    read_px(0, 0);
    drain();

    // new_frame_in mid-frame: no swap, old frame repeats
    wr(1'b1, 16'd5, 16'hCCCC, 1'b0, 1'b0);
    wr(1'b0, 16'd0, 16'h0000, 1'b0, 1'b1);
    idle();
    read_px(20, 0);
    drain();

    // last pixel coinciding with new_frame_in
    wr(1'b1, 16'd7, 16'hDDDD, 1'b1, 1'b1);
    idle();
    read_px(20, 0);
    read_px(28, 0);
    read_px(4, 4);
    drain();

    // out-of-range write, then asynchronous reset during readout
    do_reset();
    idle();
    wr(1'b1, 16'd57600, 16'h5555, 1'b0, 1'b0);
    wr(1'b1, 16'd9, 16'h7777, 1'b1, 1'b0);
    repeat (4) read_px(20, 0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_pixel_valid", fb_if.pixel_valid_out, 1'b0);
    check_eq("async_pixel_out", fb_if.pixel_out, 16'h0000);
    check_eq("async_write_ready", fb_if.write_ready_out, 1'b1);
    check_eq("async_write_error", fb_if.write_error_out, 1'b0);
    check_eq("async_frame_swap", fb_if.frame_swap_out, 1'b0);
    sb_q.delete();
    wb_m   = 1'b0;
    full_m = 1'b0;
    err_m  = 1'b0;
    tick();
    rst = 1'b0;
    park();
    idle();
    // bank contents survive reset
    read_px(20, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
